// File: rtl/ext_interrupt_gateway.sv
// ---------------------------------------------------------------------------
// ExtInterruptGateway: upstream feeder of the machine external interrupt.
// Synchronises SRC_NUM raw interrupt lines, gates each one as edge or level,
// arbitrates by fixed priority (lowest index wins, ID = index+1) and raises a
// single registered request towards interrupt_interface. An ack claims the
// selected source and marks it in service. It stays masked until software
// completes it.
//
// Ports
//   clk                        core clock
//   rst                        asynchronous active-high reset
//   all_extint_src             raw external lines (async to clk)
//   all_extint_enable          per-source enable
//   all_extint_edge_mode       1 = rising-edge source, 0 = level source
//   all_extint_complete_valid  completion strobe from software
//   all_extint_complete_id     ID being completed
//   intif_all_int_ext_ack      1-cycle ack from interrupt_interface
//   extint_intif_int_ext_req   registered external request
//   extint_all_claim_id        ID of the most recently acked source
//   extint_all_pending         pending register
//   extint_all_in_service      in-service register
// ---------------------------------------------------------------------------
module ext_interrupt_gateway #(
    parameter int SRC_NUM  = 8,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SRC_NUM-1:0]  all_extint_src,
    input  logic [SRC_NUM-1:0]  all_extint_enable,
    input  logic [SRC_NUM-1:0]  all_extint_edge_mode,
    input  logic                all_extint_complete_valid,
    input  logic [ID_WIDTH-1:0] all_extint_complete_id,
    input  logic                intif_all_int_ext_ack,
    output logic                extint_intif_int_ext_req,
    output logic [ID_WIDTH-1:0] extint_all_claim_id,
    output logic [SRC_NUM-1:0]  extint_all_pending,
    output logic [SRC_NUM-1:0]  extint_all_in_service
);

    typedef enum logic {IDLE, REQ} state_t;

    logic [SRC_NUM-1:0]  s1_q, s2_q, s3_q;
    logic [SRC_NUM-1:0]  pending_q, pending_d;
    logic [SRC_NUM-1:0]  in_service_q, in_service_d;
    logic [SRC_NUM-1:0]  eligible;
    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ID_WIDTH-1:0] sel_q, sel_d;
    logic [ID_WIDTH-1:0] claim_q, claim_d;
    logic [ID_WIDTH-1:0] best_id;
    logic                any_eligible;
    logic                sel_eligible;
    logic                ack_take;

    // Two-flop synchroniser per line, plus a third stage for rising-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= all_extint_src;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign eligible = pending_q & all_extint_enable & ~in_service_q;

    // Fixed priority: scanning downwards lets the lowest eligible index win.
    // The frozen selection is also re-checked for withdrawal while in REQ.
    always_comb begin
        best_id      = '0;
        any_eligible = 1'b0;
        sel_eligible = 1'b0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                best_id      = ID_WIDTH'(i + 1);
                any_eligible = 1'b1;
            end
            if (sel_q == ID_WIDTH'(i + 1)) begin
                sel_eligible = eligible[i];
            end
        end
    end

    // Request FSM. Selection is frozen while REQ is held, so a higher-priority
    // arrival waits for the next IDLE evaluation. An ack beats a withdrawal.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        sel_d    = sel_q;
        claim_d  = claim_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (any_eligible) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    sel_d   = best_id;
                end
            end
            REQ: begin
                if (intif_all_int_ext_ack) begin
                    ack_take = 1'b1;
                    claim_d  = sel_q;
                    state_d  = IDLE;
                    req_d    = 1'b0;
                end else if (!sel_eligible) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Pending and in-service update. A new edge beats the claim clear, and a
    // claim beats a completion of the same source in the same cycle.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        for (int i = 0; i < SRC_NUM; i++) begin
            logic rise;
            logic claimed;
            logic done;
            rise    = s2_q[i] & ~s3_q[i];
            claimed = ack_take && (sel_q == ID_WIDTH'(i + 1));
            done    = all_extint_complete_valid &&
                      (all_extint_complete_id == ID_WIDTH'(i + 1));
            if (all_extint_edge_mode[i]) begin
                pending_d[i] = rise | (pending_q[i] & ~claimed);
            end else begin
                pending_d[i] = s2_q[i];
            end
            in_service_d[i] = claimed | (in_service_q[i] & ~done);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            sel_q        <= '0;
            claim_q      <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            sel_q        <= sel_d;
            claim_q      <= claim_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    assign extint_intif_int_ext_req = req_q;
    assign extint_all_claim_id      = claim_q;
    assign extint_all_pending       = pending_q;
    assign extint_all_in_service    = in_service_q;

endmodule

// File: tb/tb_ext_interrupt_gateway.sv
// ---------------------------------------------------------------------------
// TbExtInterruptGateway: self-checking bench for ext_interrupt_gateway.
// A table of single-source vectors covers edge/level/enable combinations.
// Hand-written sequences cover priority, masking, withdrawal and reset.
// Expected claim IDs are queued when stimulus is driven and popped on ack.
// ---------------------------------------------------------------------------
module tb_ext_interrupt_gateway;

    localparam int SRC_NUM  = 8;
    localparam int ID_WIDTH = 4;

    logic                clk;
    logic                rst;
    logic [SRC_NUM-1:0]  src;
    logic [SRC_NUM-1:0]  enable;
    logic [SRC_NUM-1:0]  edgeMode;
    logic                completeValid;
    logic [ID_WIDTH-1:0] completeId;
    logic                ack;
    logic                req;
    logic [ID_WIDTH-1:0] claimId;
    logic [SRC_NUM-1:0]  pending;
    logic [SRC_NUM-1:0]  inService;

    int checks   = 0;
    int failures = 0;

    logic [ID_WIDTH-1:0] expQ[$];

    typedef struct {
        int                  srcIdx;
        bit                  isEdge;
        bit                  isEnabled;
        bit                  expReq;
        logic [ID_WIDTH-1:0] expClaim;
    } vec_t;

    vec_t vecs[7];

    ext_interrupt_gateway #(.SRC_NUM(SRC_NUM), .ID_WIDTH(ID_WIDTH)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .all_extint_src            (src),
        .all_extint_enable         (enable),
        .all_extint_edge_mode      (edgeMode),
        .all_extint_complete_valid (completeValid),
        .all_extint_complete_id    (completeId),
        .intif_all_int_ext_ack     (ack),
        .extint_intif_int_ext_req  (req),
        .extint_all_claim_id       (claimId),
        .extint_all_pending        (pending),
        .extint_all_in_service     (inService)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge; inputs and samples happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst           = 1'b1;
        src           = '0;
        enable        = '0;
        edgeMode      = '0;
        completeValid = 1'b0;
        completeId    = '0;
        ack           = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Raise one source line; edge sources get a single-cycle pulse, level
    // sources are held high until the caller drops them.
    task automatic applyStimulus(input int idx, input bit isEdge);
        src[idx] = 1'b1;
        tick();
        if (isEdge) src[idx] = 1'b0;
        tick();
        tick();
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (req !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checkOutput({name, "_req_seen"}, req, 1);
    endtask

    task automatic ackAndScore(input string name);
        logic [ID_WIDTH-1:0] exp;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        exp = '0;
        if (expQ.size() > 0) exp = expQ.pop_front();
        checkOutput({name, "_claim"}, claimId, exp);
        checkOutput({name, "_req_low"}, req, 0);
    endtask

    task automatic complete(input logic [ID_WIDTH-1:0] id);
        completeValid = 1'b1;
        completeId    = id;
        tick();
        completeValid = 1'b0;
        completeId    = '0;
    endtask

    initial begin
        rst           = 1'b1;
        src           = '0;
        enable        = '0;
        edgeMode      = '0;
        completeValid = 1'b0;
        completeId    = '0;
        ack           = 1'b0;

        vecs[0] = '{srcIdx: 2, isEdge: 1, isEnabled: 1, expReq: 1, expClaim: 4'd3};
        vecs[1] = '{srcIdx: 0, isEdge: 1, isEnabled: 1, expReq: 1, expClaim: 4'd1};
        vecs[2] = '{srcIdx: 7, isEdge: 1, isEnabled: 1, expReq: 1, expClaim: 4'd8};
        vecs[3] = '{srcIdx: 5, isEdge: 0, isEnabled: 1, expReq: 1, expClaim: 4'd6};
        vecs[4] = '{srcIdx: 3, isEdge: 1, isEnabled: 0, expReq: 0, expClaim: 4'd0};
        vecs[5] = '{srcIdx: 6, isEdge: 0, isEnabled: 0, expReq: 0, expClaim: 4'd0};
        vecs[6] = '{srcIdx: 4, isEdge: 0, isEnabled: 1, expReq: 1, expClaim: 4'd5};

        // Reset state.
        doReset();
        tick();
        checkOutput("rst_req", req, 0);
        checkOutput("rst_claim", claimId, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_inservice", inService, 0);

        // Ack while idle is ignored.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checkOutput("idle_ack_claim", claimId, 0);
        checkOutput("idle_ack_inservice", inService, 0);
        checkOutput("idle_ack_req", req, 0);

        // Table of single-source vectors: pending 3 cycles after the line
        // rises, request one cycle later, ack claims and masks the source.
        for (int v = 0; v < 7; v++) begin
            doReset();
            edgeMode = vecs[v].isEdge ? '1 : '0;
            enable   = vecs[v].isEnabled ? (SRC_NUM'(1) << vecs[v].srcIdx) : '0;
            if (vecs[v].expReq) expQ.push_back(vecs[v].expClaim);
            applyStimulus(vecs[v].srcIdx, vecs[v].isEdge);
            checkOutput($sformatf("v%0d_pending", v), pending, SRC_NUM'(1) << vecs[v].srcIdx);
            checkOutput($sformatf("v%0d_req_early", v), req, 0);
            tick();
            checkOutput($sformatf("v%0d_req", v), req, 32'(vecs[v].expReq));
            if (vecs[v].expReq) begin
                ackAndScore($sformatf("v%0d", v));
                checkOutput($sformatf("v%0d_inservice", v), inService,
                            SRC_NUM'(1) << vecs[v].srcIdx);
            end
            src = '0;
        end

        // Priority between two level sources, then back-to-back and completion.
        doReset();
        edgeMode = '0;
        enable   = '1;
        src      = 8'b0010_0010;
        expQ.push_back(4'd2);
        expQ.push_back(4'd6);
        waitReq("prio1");
        ackAndScore("prio1");
        checkOutput("prio1_inservice", inService, 8'h02);
        tick();
        checkOutput("prio_b2b_req", req, 1);
        complete(4'd2);
        checkOutput("prio_complete_inservice", inService, 8'h00);
        checkOutput("prio_req_held", req, 1);
        ackAndScore("prio2");
        checkOutput("prio2_inservice", inService, 8'h20);
        src = '0;

        // Masking: an edge during service stays pending but is held back.
        doReset();
        edgeMode = '1;
        enable   = '1;
        expQ.push_back(4'd1);
        applyStimulus(0, 1'b1);
        waitReq("mask1");
        ackAndScore("mask1");
        applyStimulus(0, 1'b1);
        tick();
        tick();
        checkOutput("mask_pending", pending, 8'h01);
        checkOutput("mask_req", req, 0);
        complete(4'd0);
        tick();
        checkOutput("complete0_inservice", inService, 8'h01);
        checkOutput("complete0_req", req, 0);
        complete(4'd9);
        tick();
        checkOutput("complete9_inservice", inService, 8'h01);
        checkOutput("complete9_req", req, 0);
        complete(4'd1);
        checkOutput("mask_complete_inservice", inService, 8'h00);
        checkOutput("mask_complete_req_wait", req, 0);
        tick();
        checkOutput("mask_complete_req", req, 1);
        expQ.push_back(4'd1);
        ackAndScore("mask2");

        // Withdrawal: dropping the enable before ack retracts the request.
        doReset();
        edgeMode = '0;
        enable   = 8'h10;
        src      = 8'h10;
        waitReq("wd");
        enable = '0;
        tick();
        checkOutput("wd_req", req, 0);
        checkOutput("wd_claim", claimId, 0);
        tick();
        checkOutput("wd_req_stays", req, 0);
        src = '0;

        // Reset asserted while a request is outstanding.
        doReset();
        edgeMode = '1;
        enable   = '1;
        expQ.push_back(4'd1);
        applyStimulus(0, 1'b1);
        waitReq("rq1");
        ackAndScore("rq1");
        applyStimulus(2, 1'b1);
        waitReq("rq2");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_req", req, 0);
        checkOutput("midrst_claim", claimId, 0);
        checkOutput("midrst_pending", pending, 0);
        checkOutput("midrst_inservice", inService, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("postrst_req", req, 0);

        checkOutput("queue_empty", 32'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
